// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory controller: access-size encodings,
// controller state encoding and the alignment-fault rule.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } dmem_state_e;

  // A request faults when it is misaligned for its size or uses the reserved size.
  function automatic logic access_fault(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lo[0];
      SZ_WORD: return (lo != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store byte-enables and replicated write
// word, plus extraction and sign/zero extension of load data (little-endian).
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        ld_unsigned_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wword_o,
  output logic [31:0] ldata_o
);

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic uns);
    logic signed [7:0]  s;
    logic signed [31:0] w;
    s = b;
    w = s;
    return uns ? {24'h0, b} : w;
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic uns);
    logic signed [15:0] s;
    logic signed [31:0] w;
    s = h;
    w = s;
    return uns ? {16'h0, h} : w;
  endfunction

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rword_i[{addr_lo_i, 3'b000} +: 8];
  assign half_sel = rword_i[{addr_lo_i[1], 4'b0000} +: 16];

  always_comb begin
    be_o    = 4'b0000;
    wword_o = wdata_i;
    ldata_o = 32'h0;
    case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wword_o = {4{wdata_i[7:0]}};
        ldata_o = ext8(byte_sel, ld_unsigned_i);
      end
      SZ_HALF: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wword_o = {2{wdata_i[15:0]}};
        ldata_o = ext16(half_sel, ld_unsigned_i);
      end
      SZ_WORD: begin
        be_o    = 4'b1111;
        ldata_o = rword_i;
      end
      default: begin
        be_o = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Word-organised data memory with byte/halfword/word loads and stores,
// a programmable number of wait states and an alignment error response.
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [1:0]            size,
  input  logic                  ld_unsigned,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  ready,
  output logic                  busy,
  output logic                  err
);

  localparam int DEPTH = 1 << (ADDR_WIDTH - 2);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  dmem_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic                  we_q, uns_q;
  logic [1:0]            size_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;

  logic [31:0] mem_q [DEPTH];

  // While waiting the captured request drives the access; otherwise the live
  // inputs do, which lets a zero-wait access complete on its acceptance edge.
  logic                  in_wait;
  logic                  eff_we, eff_uns;
  logic [1:0]            eff_size;
  logic [ADDR_WIDTH-1:0] eff_addr;
  logic [31:0]           eff_wdata;

  assign in_wait   = (state_q == ST_WAIT);
  assign eff_we    = in_wait ? we_q    : we;
  assign eff_uns   = in_wait ? uns_q   : ld_unsigned;
  assign eff_size  = in_wait ? size_q  : size;
  assign eff_addr  = in_wait ? addr_q  : addr;
  assign eff_wdata = in_wait ? wdata_q : wdata;

  logic [ADDR_WIDTH-3:0] widx;
  logic [31:0]           rword, wword, ldata;
  logic [3:0]            be;
  logic                  accept, do_access, mem_we;

  assign widx   = eff_addr[ADDR_WIDTH-1:2];
  assign rword  = mem_q[widx];
  assign accept = (state_q != ST_WAIT) && req;

  dmem_lane_align u_align (
    .size_i       (eff_size),
    .ld_unsigned_i(eff_uns),
    .addr_lo_i    (eff_addr[1:0]),
    .wdata_i      (eff_wdata),
    .rword_i      (rword),
    .be_o         (be),
    .wword_o      (wword),
    .ldata_o      (ldata)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = 32'h0;
    err_d     = 1'b0;
    do_access = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (req) begin
          if (access_fault(size, addr[1:0])) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end else if (WAIT_CYCLES == 0) begin
            do_access = 1'b1;
            state_d   = ST_DONE;
            rdata_d   = we ? 32'h0 : ldata;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          do_access = 1'b1;
          state_d   = ST_DONE;
          rdata_d   = we_q ? 32'h0 : ldata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Gating with rst_n keeps a held request from writing while reset is asserted.
  assign mem_we = do_access && eff_we && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= we;
      uns_q   <= ld_unsigned;
      size_q  <= size;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[widx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  assign rdata = rdata_q;
  assign err   = err_q;
  assign ready = (state_q == ST_DONE);
  assign busy  = (state_q == ST_WAIT);

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench: stimulus pushes expected responses, a monitor pops and
// compares data, error flag and completion cycle whenever ready is seen.
module tb_data_memory_ctrl;

  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, R = 2'b11;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        req_a, we_a, uns_a, ready_a, busy_a, err_a;
  logic [1:0]  size_a;
  logic [9:0]  addr_a;
  logic [31:0] wdata_a, rdata_a;

  logic        req_b, we_b, uns_b, ready_b, busy_b, err_b;
  logic [1:0]  size_b;
  logic [9:0]  addr_b;
  logic [31:0] wdata_b, rdata_b;

  data_memory_ctrl #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .we(we_a), .size(size_a),
    .ld_unsigned(uns_a), .addr(addr_a), .wdata(wdata_a), .rdata(rdata_a),
    .ready(ready_a), .busy(busy_a), .err(err_a)
  );

  data_memory_ctrl #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .we(we_b), .size(size_b),
    .ld_unsigned(uns_b), .addr(addr_b), .wdata(wdata_b), .rdata(rdata_b),
    .ready(ready_b), .busy(busy_b), .err(err_b)
  );

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic dump_word(input int idx);
    $display("[TB] dmem_a word %0d = 0x%08h", idx, dut_a.mem_q[idx]);
  endtask

  always @(negedge clk) begin
    if (ready_a) begin
      if (qa.size() == 0) begin
        tests++; fails++;
        $display("FAIL a_unexpected_ready: ready=1 at cycle %0d, expected no response", cyc);
      end else begin
        ea = qa.pop_front();
        check({ea.name, "_rdata"}, rdata_a, ea.rdata);
        check({ea.name, "_err"}, {31'b0, err_a}, {31'b0, ea.err});
        check({ea.name, "_cycle"}, 32'(cyc), 32'(ea.cyc));
      end
    end
    if (ready_b) begin
      if (qb.size() == 0) begin
        tests++; fails++;
        $display("FAIL b_unexpected_ready: ready=1 at cycle %0d, expected no response", cyc);
      end else begin
        eb = qb.pop_front();
        check({eb.name, "_rdata"}, rdata_b, eb.rdata);
        check({eb.name, "_err"}, {31'b0, err_b}, {31'b0, eb.err});
        check({eb.name, "_cycle"}, 32'(cyc), 32'(eb.cyc));
      end
    end
  end

  task automatic wait_ready_a(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ready_a) seen = 1'b1;
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL %s_timeout: ready=0 for 20 cycles, expected 1", name);
    end
  endtask

  // Single request on the two-wait-state instance; inputs are scrambled right
  // after acceptance so the response must come from the captured request.
  task automatic issue_a(input string name, input logic w, input logic [1:0] sz,
                         input logic u, input logic [9:0] ad, input logic [31:0] wd,
                         input logic [31:0] er, input logic ee);
    exp_t e;
    @(negedge clk);
    req_a = 1'b1; we_a = w; size_a = sz; uns_a = u; addr_a = ad; wdata_a = wd;
    e.name = name; e.rdata = er; e.err = ee; e.cyc = cyc + 1 + (ee ? 0 : 2);
    qa.push_back(e);
    @(posedge clk);
    #1;
    req_a = 1'b0; wdata_a = ~wd; addr_a = ad ^ 10'h3ff; uns_a = ~u;
    wait_ready_a(name);
  endtask

  task automatic push_a(input string name, input logic [31:0] er, input int c);
    exp_t e;
    e.name = name; e.rdata = er; e.err = 1'b0; e.cyc = c;
    qa.push_back(e);
  endtask

  task automatic push_b(input string name, input logic [31:0] er, input int c);
    exp_t e;
    e.name = name; e.rdata = er; e.err = 1'b0; e.cyc = c;
    qb.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0;
    req_a = 1'b0; we_a = 1'b0; size_a = W; uns_a = 1'b0; addr_a = '0; wdata_a = '0;
    req_b = 1'b0; we_b = 1'b0; size_b = W; uns_b = 1'b0; addr_b = '0; wdata_b = '0;

    @(negedge clk);
    check("rst_ready", {31'b0, ready_a}, 32'h0);
    check("rst_busy",  {31'b0, busy_a},  32'h0);
    check("rst_err",   {31'b0, err_a},   32'h0);
    check("rst_rdata", rdata_a, 32'h0);
    check("rst_b_ready", {31'b0, ready_b}, 32'h0);

    // A request held during reset must not be taken.
    req_a = 1'b1; we_a = 1'b1; size_a = W; addr_a = 10'h50; wdata_a = 32'h0;
    @(posedge clk);
    #1;
    check("rst_no_accept_busy", {31'b0, busy_a}, 32'h0);
    req_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    issue_a("sw_50",   1'b1, W, 1'b0, 10'h50, 32'hDEADBEEF, 32'h0,        1'b0);
    issue_a("lw_50",   1'b0, W, 1'b0, 10'h50, 32'h0,        32'hDEADBEEF, 1'b0);
    issue_a("sb_51",   1'b1, B, 1'b0, 10'h51, 32'h12345680, 32'h0,        1'b0);
    issue_a("lb_51",   1'b0, B, 1'b0, 10'h51, 32'h0,        32'hFFFFFF80, 1'b0);
    issue_a("lbu_51",  1'b0, B, 1'b1, 10'h51, 32'h0,        32'h00000080, 1'b0);
    issue_a("lw_50b",  1'b0, W, 1'b0, 10'h50, 32'h0,        32'hDEAD80EF, 1'b0);
    issue_a("lh_53",   1'b0, H, 1'b0, 10'h53, 32'h0,        32'h0,        1'b1);
    issue_a("rsv_50",  1'b1, R, 1'b0, 10'h50, 32'h0,        32'h0,        1'b1);
    issue_a("sw_52",   1'b1, W, 1'b0, 10'h52, 32'h0,        32'h0,        1'b1);
    issue_a("lw_50c",  1'b0, W, 1'b0, 10'h50, 32'h0,        32'hDEAD80EF, 1'b0);

    // Three loads with req held: one response every three cycles, busy
    // dropping only on the response cycles.
    @(negedge clk);
    req_a = 1'b1; we_a = 1'b0; size_a = W; uns_a = 1'b0; addr_a = 10'h50;
    push_a("b2b_lw",  32'hDEAD80EF, cyc + 3);
    push_a("b2b_lbu", 32'h00000080, cyc + 6);
    push_a("b2b_lh",  32'hFFFFDEAD, cyc + 9);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check($sformatf("b2b_busy_%0d", k), {31'b0, busy_a}, {31'b0, (k % 3) != 2});
      if (k == 0) begin size_a = B; uns_a = 1'b1; addr_a = 10'h51; end
      if (k == 3) begin size_a = H; uns_a = 1'b0; addr_a = 10'h52; end
      if (k == 6) req_a = 1'b0;
    end

    issue_a("sh_52",   1'b1, H, 1'b0, 10'h52, 32'hFFFF7E01, 32'h0,        1'b0);
    issue_a("lw_50d",  1'b0, W, 1'b0, 10'h50, 32'h0,        32'h7E0180EF, 1'b0);
    issue_a("lh_50",   1'b0, H, 1'b0, 10'h50, 32'h0,        32'hFFFF80EF, 1'b0);
    issue_a("lhu_50",  1'b0, H, 1'b1, 10'h50, 32'h0,        32'h000080EF, 1'b0);
    issue_a("lh_52",   1'b0, H, 1'b0, 10'h52, 32'h0,        32'h00007E01, 1'b0);

    // Reset in the middle of a store's wait states aborts it.
    issue_a("sw_54",   1'b1, W, 1'b0, 10'h54, 32'h11112222, 32'h0,        1'b0);
    @(negedge clk);
    req_a = 1'b1; we_a = 1'b1; size_a = W; addr_a = 10'h54; wdata_a = 32'h12345678;
    @(posedge clk);
    #1;
    req_a = 1'b0;
    check("abort_busy", {31'b0, busy_a}, 32'h1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_ready", {31'b0, ready_a}, 32'h0);
    check("abort_busy_clr", {31'b0, busy_a}, 32'h0);
    check("abort_err", {31'b0, err_a}, 32'h0);
    check("abort_rdata", rdata_a, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    issue_a("lw_54",   1'b0, W, 1'b0, 10'h54, 32'h0,        32'h11112222, 1'b0);

    // Zero-wait instance: store then load back-to-back, one response per cycle.
    @(negedge clk);
    req_b = 1'b1; we_b = 1'b1; size_b = W; uns_b = 1'b0; addr_b = 10'h0; wdata_b = 32'hCAFEF00D;
    push_b("z_sw_0", 32'h0, cyc + 1);
    @(posedge clk);
    #1;
    we_b = 1'b0; wdata_b = 32'h0;
    push_b("z_lw_0", 32'hCAFEF00D, cyc + 1);
    @(posedge clk);
    #1;
    req_b = 1'b0;

    dump_word(20);

    for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clk);
    while (qa.size() != 0) begin
      ea = qa.pop_front();
      tests++; fails++;
      $display("FAIL %s_missing: no response, expected ready at cycle %0d", ea.name, ea.cyc);
    end
    while (qb.size() != 0) begin
      eb = qb.pop_front();
      tests++; fails++;
      $display("FAIL %s_missing: no response, expected ready at cycle %0d", eb.name, eb.cyc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, SHALL be the byte-address width; storage SHALL be 2**(ADDR_WIDTH-2) 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 2, range 0..15, SHALL be the wait states inserted before each access.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req  input  1  SHALL request an access; sampled only when busy=0.
REQ-006 we  input  1  SHALL select store (1) or load (0).
REQ-007 size  input  2  SHALL encode access size: 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 ld_unsigned  input  1  SHALL select zero-extension (1) or sign-extension (0) for byte/halfword loads.
REQ-009 addr  input  ADDR_WIDTH  SHALL be the byte address.
REQ-010 wdata  input  32  SHALL carry store data, right-aligned (bits 7:0 for byte, 15:0 for halfword).
REQ-011 rdata  output  32  SHALL carry load data, extended to 32 bits and valid while ready=1.
REQ-012 ready  output  1  SHALL pulse high for exactly one cycle per accepted request.
REQ-013 busy  output  1  SHALL be high from the cycle after acceptance until ready is asserted.
REQ-014 err  output  1  SHALL be high together with ready when the request was misaligned or used size=11.

Function
REQ-015 FSM states SHALL be IDLE, WAIT, DONE; reset state is IDLE.
REQ-016 Acceptance: in IDLE or DONE, req=1 at posedge SHALL capture we, size, ld_unsigned, addr, wdata; later input changes SHALL be ignored until the next acceptance.
REQ-017 Error check at acceptance: size=01 with addr[0]=1, size=10 with addr[1:0]!=0, or size=11 SHALL go directly to DONE with err=1 and rdata=0; memory SHALL NOT be written.
REQ-018 Valid request with WAIT_CYCLES>0: go to WAIT and load a counter with WAIT_CYCLES-1; decrement each cycle; at zero perform the access and go to DONE.
REQ-019 Valid request with WAIT_CYCLES=0: perform the access on the acceptance edge and go to DONE.
REQ-020 Latency: ready SHALL rise WAIT_CYCLES+1 cycles after the acceptance edge.
REQ-021 Store: only the addressed byte lanes SHALL be written, little-endian (lane = addr[1:0]; halfword lanes addr[1]*2 .. +1); other lanes unchanged.
REQ-022 Load: the selected lanes SHALL be shifted to bit 0 and sign- or zero-extended per ld_unsigned; word loads SHALL ignore ld_unsigned.
REQ-023 Store completion: ready=1 and err=0; rdata SHALL be 0.
REQ-024 DONE SHALL last one cycle: with req=1 it accepts the next request (back-to-back throughput of one per WAIT_CYCLES+1 cycles, or one every cycle when the next request is an error), otherwise it returns to IDLE.
REQ-025 Word index SHALL be addr[ADDR_WIDTH-1:2]; no wrap or out-of-range condition exists.

Reset
REQ-026 rst_n=0 SHALL immediately force state=IDLE, counter=0, ready=0, busy=0, err=0, rdata=0.
REQ-027 Reset during WAIT SHALL abort the access without writing memory; the memory array SHALL NOT be reset.
REQ-028 req SHALL NOT be accepted on the first posedge at which rst_n is sampled low.

Structure
REQ-029 Shared package dmem_pkg SHALL hold size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state enum.
REQ-030 One sub-module, dmem_lane_align, SHALL be purely combinational: it builds the store byte-enable and write word, and the extracted, extended load word.
REQ-031 A debug task SHALL print a given word index and its contents.

Verification (WAIT_CYCLES=2 unless stated)
REQ-032 Store word 0xDEADBEEF at addr 0x50, then load word at 0x50 -> ready 3 cycles after acceptance, rdata=0xDEADBEEF, err=0.
REQ-033 Store byte 0x80 at 0x51, then lb at 0x51 -> 0xFFFFFF80; lbu at 0x51 -> 0x00000080; lw at 0x50 -> 0xDEAD80EF.
REQ-034 Halfword load at 0x53 -> after 1 cycle, ready=1, err=1, rdata=0; word at 0x50 unchanged.
REQ-035 Hold req=1 for 3 back-to-back loads -> ready pulses every 3 cycles, busy low only on DONE cycles.
REQ-036 Assert rst_n=0 during WAIT of a store of 0x12345678 to 0x54 -> outputs clear immediately, later load at 0x54 returns the prior value.
REQ-037 WAIT_CYCLES=0: store then load 0xCAFEF00D at 0x0 -> ready every cycle, load data correct.
